usb_cmd_parser: RTL and testbench
=================================

Name:
usb_cmd_parser

Overview:
- Receive-side consumer of the USB byte interface: `byte_received` and `read_data[7:0]` from the USB core.
- Frames the incoming byte stream into command packets of the form SYNC, ADDR, LEN, payload[LEN], CHK.
- Verifies the XOR checksum and buffers the payload.
- After a good checksum, replays the payload as consecutive register-write strobes to downstream logic (LED/register bank).
- Flags and counts malformed packets.

Parameters:
- MAX_LEN, 8: maximum payload bytes per packet; also the payload buffer depth.
- SYNC_BYTE, 8'hA5: start-of-packet marker.
- TIMEOUT_CYCLES, 5000000: maximum clock cycles between bytes inside a packet (100 ms at 50 MHz).

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- reset input 1: asynchronous, active-high reset.
- byte_received input 1: level from the USB core; each rising edge marks a new byte on `read_data`.
- read_data input 8: received byte; valid when the `byte_received` rising edge is detected.
- wr_valid output 1: one write strobe per payload byte.
- wr_addr output 8: write address, ADDR + byte index, modulo 256.
- wr_data output 8: payload byte.
- pkt_done output 1: one-cycle pulse when a good packet has been fully emitted.
- pkt_error output 1: one-cycle pulse on any packet error.
- err_count output 8: saturating error counter.
- busy output 1: high whenever state != IDLE.

Behaviour:
- **Edge detect.** `byte_prev` is a register; `edge = byte_received & ~byte_prev`.
  - `byte_prev` resets to 1, so a high level at reset release is not a byte.
  - `read_data` is sampled in the edge cycle.
- **Reset values.** All outputs 0; state IDLE; checksum, index and timeout counters 0.
  - Reset mid-packet discards the packet and increments nothing.
- **States:** IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CHK, EMIT.
- **IDLE.**
  - Edge with `read_data == SYNC_BYTE` -> GET_ADDR; clear checksum.
  - Other bytes are ignored with no error.
- **GET_ADDR.** Edge: latch ADDR; `chk = ADDR`; -> GET_LEN.
- **GET_LEN.** On edge:
  - LEN > MAX_LEN -> error, go to IDLE.
  - Otherwise latch LEN, `chk ^= LEN`, index = 0.
  - LEN == 0 -> GET_CHK; else -> GET_DATA.
- **GET_DATA.** Each edge:
  - `buf[index] = byte`; `chk ^= byte`; index++.
  - When index reaches LEN -> GET_CHK.
- **GET_CHK.** On edge:
  - byte != chk -> error, go to IDLE.
  - Match with LEN == 0 -> `pkt_done` pulses the next cycle; go to IDLE.
  - Match with LEN > 0 -> EMIT, index = 0.
- **EMIT.** One write per cycle.
  - `wr_valid = 1`, `wr_addr = ADDR + index` (8-bit wrap), `wr_data = buf[index]`.
  - First strobe occurs the cycle after the CHK edge.
  - `pkt_done` asserts together with the last `wr_valid`; then go to IDLE.
  - Exactly LEN consecutive strobes are produced; no gaps, no back-pressure.
- **Timeout.**
  - The counter resets on every edge and in IDLE, and is frozen in EMIT.
  - In GET_* states, reaching TIMEOUT_CYCLES-1 without an edge -> error, go to IDLE.
- **Overrun.** An edge during EMIT is dropped and raises an error; EMIT still completes.
- **Error handling.**
  - Every error produces a `pkt_error` pulse for one cycle.
  - `err_count` increments and saturates at 255.
- **Simultaneous events.** An edge in the same cycle as a timeout is processed as a byte; no timeout fires.

Test Plan:
- Bytes A5 10 02 33 44 65 -> two consecutive strobes:
  - (10,33), then (11,44);
  - `pkt_done` with the second strobe; `pkt_error` never asserts; `err_count` = 0.
- Wrap: A5 FF 02 01 02 FE -> strobes (FF,01) then (00,02); `pkt_done` = 1 once.
- Zero length: A5 20 00 20 -> no `wr_valid`; one `pkt_done` pulse the cycle after the CHK edge.
- Bad checksum A5 10 01 55 00 -> no strobes; one `pkt_error` pulse; `err_count` = 1.
  - Following valid packet A5 30 01 7E 4F -> single strobe (30,7E).
- Garbage and limits:
  - Garbage 00 FF 12 before a valid packet -> ignored, `err_count` unchanged.
  - LEN = 09 with MAX_LEN = 8 -> error, state returns to IDLE.
- Timeout (TIMEOUT_CYCLES=100): send A5 10 then stall 100 cycles -> `pkt_error` pulse, `busy` = 0.
- Reset and saturation:
  - Assert reset mid-GET_DATA -> all outputs 0 immediately; no strobes after release.
  - 300 bad packets -> `err_count` holds 255.

Source files
------------

// File: rtl/usb_cmd_parser_if.sv
// usb_cmd_parser_if: received-byte input and register-write output bundle of the command parser
interface usb_cmd_parser_if;
  logic       byte_received;
  logic [7:0] read_data;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_done;
  logic       pkt_error;
  logic [7:0] err_count;
  logic       busy;
  modport master (
    output byte_received, read_data,
    input  wr_valid, wr_addr, wr_data, pkt_done, pkt_error, err_count, busy
  );
  modport slave (
    input  byte_received, read_data,
    output wr_valid, wr_addr, wr_data, pkt_done, pkt_error, err_count, busy
  );
endinterface

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: frames SYNC/ADDR/LEN/payload/CHK packets and replays payload as register writes
module usb_cmd_parser #(
  parameter int         MAX_LEN        = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5000000
) (
  input logic             CLOCK_50,
  input logic             reset,
  usb_cmd_parser_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CHK, EMIT} state_t;
  state_t state, state_d;
  logic byte_prev, ev, tout, last, err, done_d, done_z, err_z;
  logic [7:0] b, addr, chk, err_count;
  logic [IW-1:0] len, idx;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [2**AW];
  assign b = bus.read_data;
  assign ev = bus.byte_received & ~byte_prev;
  assign last = idx == len - IW'(1);
  // a byte arriving on the expiry cycle wins over the timeout
  assign tout = state inside {GET_ADDR, GET_LEN, GET_DATA, GET_CHK} && !ev && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state;
    err = 1'b0;
    done_d = 1'b0;
    if (tout) begin
      state_d = IDLE;
      err = 1'b1;
    end else case (state)
      IDLE:     state_d = (ev && b == SYNC_BYTE) ? GET_ADDR : IDLE;
      GET_ADDR: state_d = ev ? GET_LEN : GET_ADDR;
      GET_LEN: if (ev) begin
        err = b > 8'(MAX_LEN);
        state_d = err ? IDLE : (b == 8'd0 ? GET_CHK : GET_DATA);
      end
      GET_DATA: state_d = (ev && idx + IW'(1) == len) ? GET_CHK : GET_DATA;
      GET_CHK: if (ev) begin
        err = b != chk;
        done_d = !err && len == '0;
        state_d = (err || done_d) ? IDLE : EMIT;
      end
      EMIT: begin
        err = ev;
        state_d = last ? IDLE : EMIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      byte_prev <= 1'b1;
      addr <= '0;
      chk <= '0;
      len <= '0;
      idx <= '0;
      tcnt <= '0;
      err_z <= 1'b0;
      done_z <= 1'b0;
      err_count <= '0;
    end else begin
      byte_prev <= bus.byte_received;
      err_z <= err;
      done_z <= done_d;
      if (err) err_count <= err_count + 8'(err_count != 8'hFF);
      tcnt <= (ev || state == IDLE) ? '0 : (state == EMIT ? tcnt : tcnt + TW'(1));
      case (state)
        IDLE: if (ev && b == SYNC_BYTE) chk <= '0;
        GET_ADDR: if (ev) begin
          addr <= b;
          chk <= b;
        end
        GET_LEN: if (ev && b <= 8'(MAX_LEN)) begin
          len <= b[IW-1:0];
          chk <= chk ^ b;
          idx <= '0;
        end
        GET_DATA: if (ev) begin
          chk <= chk ^ b;
          idx <= idx + IW'(1);
        end
        GET_CHK: if (ev) idx <= '0;
        EMIT: idx <= idx + IW'(1);
        default: ;
      endcase
    end
  always_ff @(posedge CLOCK_50)
    if (state == GET_DATA && ev) mem[idx[AW-1:0]] <= b;
  assign bus.wr_valid = state == EMIT;
  assign bus.wr_addr = bus.wr_valid ? addr + 8'(idx) : '0;
  assign bus.wr_data = bus.wr_valid ? mem[idx[AW-1:0]] : '0;
  assign bus.pkt_done = (bus.wr_valid && last) || done_z;
  assign bus.pkt_error = err_z;
  assign bus.err_count = err_count;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb_usb_cmd_parser: random and directed packets checked against a packet-level reference model
module tb_usb_cmd_parser;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  usb_cmd_parser_if bus();
  usb_cmd_parser #(.MAX_LEN(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .bus(bus)
  );
  int checks = 0, failures = 0;
  int done_alone = 0, err_pulses = 0;
  int exp_done_alone = 0, exp_err = 0, total_err = 0;
  int op = 0, ep = 0;
  logic [16:0] obs[$], exp_q[$];
  logic [7:0] q[$];
  logic s_valid, s_done;
  logic [7:0] s_wa, s_wd;
  always @(negedge clk)
    if (!rst) begin
      if (bus.wr_valid) obs.push_back({bus.pkt_done, bus.wr_addr, bus.wr_data});
      else if (bus.pkt_done) done_alone++;
      if (bus.pkt_error) err_pulses++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] v, input int gap);
    @(negedge clk);
    bus.byte_received = 1'b1;
    bus.read_data = v;
    @(negedge clk);
    s_valid = bus.wr_valid;
    s_done = bus.pkt_done;
    s_wa = bus.wr_addr;
    s_wd = bus.wr_data;
    bus.byte_received = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_raw(input logic [7:0] p[$], input int last_gap);
    foreach (p[i]) send_byte(p[i], i == p.size() - 1 ? last_gap : $urandom_range(0, 3));
  endtask
  // packet-level expectation: bad length or checksum is one error, otherwise LEN writes
  task automatic model(input logic [7:0] p[$]);
    int n;
    logic [7:0] c;
    n = int'(p[2]);
    if (n > 8) begin
      exp_err++;
      total_err++;
      return;
    end
    c = 8'h00;
    for (int i = 1; i < 3 + n; i++) c ^= p[i];
    if (c != p[3 + n]) begin
      exp_err++;
      total_err++;
    end else if (n == 0) exp_done_alone++;
    else for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 8'(int'(p[1]) + i), p[3 + i]});
  endtask
  task automatic verify(input string tag);
    int n;
    @(posedge clk);
    #1;
    check({tag, "_nwr"}, obs.size() - op, exp_q.size() - ep);
    n = (obs.size() - op < exp_q.size() - ep) ? obs.size() - op : exp_q.size() - ep;
    for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(obs[op + i]), 32'(exp_q[ep + i]));
    op = obs.size();
    ep = exp_q.size();
    check({tag, "_done0"}, done_alone, exp_done_alone);
    check({tag, "_errp"}, err_pulses, exp_err);
    check({tag, "_errcnt"}, bus.err_count, total_err > 255 ? 255 : total_err);
  endtask
  initial begin
    bus.byte_received = 1'b1;
    bus.read_data = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.wr_valid, 0);
    check("rst_done", bus.pkt_done, 0);
    check("rst_err", bus.pkt_error, 0);
    check("rst_errcnt", bus.err_count, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_high_busy", bus.busy, 0);
    bus.byte_received = 1'b0;
    repeat (2) @(negedge clk);
    q = {8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
    send_raw(q, 0);
    check("first_valid", s_valid, 1);
    check("first_addr", s_wa, 8'h10);
    check("first_data", s_wd, 8'h33);
    repeat (5) @(negedge clk);
    model(q);
    verify("basic");
    q = {8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE};
    send_raw(q, 5);
    model(q);
    verify("wrap");
    q = {8'hA5, 8'h20, 8'h00, 8'h20};
    send_raw(q, 0);
    check("zlen_done", s_done, 1);
    check("zlen_valid", s_valid, 0);
    repeat (3) @(negedge clk);
    model(q);
    verify("zlen");
    q = {8'hA5, 8'h10, 8'h01, 8'h55, 8'h00};
    send_raw(q, 3);
    model(q);
    q = {8'hA5, 8'h30, 8'h01, 8'h7E, 8'h4F};
    send_raw(q, 4);
    model(q);
    verify("badchk");
    send_raw({8'h00, 8'hFF, 8'h12}, 2);
    q = {8'hA5, 8'h40, 8'h01, 8'h99, 8'hD8};
    send_raw(q, 4);
    model(q);
    verify("garbage");
    q = {8'hA5, 8'h10, 8'h09};
    send_raw(q, 3);
    model(q);
    check("len9_busy", bus.busy, 0);
    verify("len9");
    send_raw({8'hA5, 8'h10}, 50);
    check("to_busy_mid", bus.busy, 1);
    repeat (60) @(negedge clk);
    check("to_busy", bus.busy, 0);
    exp_err++;
    total_err++;
    verify("timeout");
    q = {8'hA5, 8'h60, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    q.push_back(8'h60 ^ 8'h08 ^ 8'h08);
    send_raw(q, 0);
    send_byte(8'h5A, 12);
    model(q);
    exp_err++;
    total_err++;
    verify("overrun");
    for (int k = 0; k < 40; k++) begin
      int n;
      logic [7:0] c;
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)) == 8'hA5 ? 8'h00 : 8'($urandom_range(0, 255)), 1);
      n = $urandom_range(0, 9);
      q = {8'hA5, 8'($urandom_range(0, 255)), 8'(n)};
      if (n <= 8) begin
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        c = 8'h00;
        foreach (q[i]) if (i > 0) c ^= q[i];
        if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
        q.push_back(c);
      end
      send_raw(q, n + 3);
      model(q);
    end
    verify("random");
    send_raw({8'hA5, 8'h50, 8'h04, 8'h11, 8'h22}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.wr_valid, 0);
    check("mid_rst_done", bus.pkt_done, 0);
    check("mid_rst_err", bus.pkt_error, 0);
    check("mid_rst_errcnt", bus.err_count, 0);
    check("mid_rst_busy", bus.busy, 0);
    total_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_raw({8'h33, 8'h44, 8'h10}, 12);
    check("mid_rst_busy2", bus.busy, 0);
    verify("midrst");
    for (int k = 0; k < 300; k++) begin
      q = {8'hA5, 8'h00, 8'h09};
      send_raw(q, 1);
      model(q);
    end
    verify("sat");
    q = {8'hA5, 8'h70, 8'h01, 8'hAA, 8'hDB};
    send_raw(q, 4);
    model(q);
    verify("after_sat");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
